// File: rtl/ffe_pkg.sv
// Shared constants and state encoding for the FFE LMS adaptation engine.
package ffe_pkg;
   localparam int FFE_IN_BW     = 11;   // S(11,7)
   localparam int FFE_EQ_BW     = 9;    // S(9,6)
   localparam int FFE_COEF_BW   = 9;    // S(9,7)
   localparam int FFE_N_COEF    = 7;
   localparam int FFE_EXT_BW    = 10;
   localparam int FFE_ALIGN_DLY = 2;
   localparam int FFE_CENTER    = 3;
   localparam int MU_BW         = 4;
   localparam int TLEN_BW       = 16;

   localparam int IN_FRAC   = 7;
   localparam int EQ_FRAC   = 6;
   localparam int COEF_FRAC = 7;
   localparam int COEF_ONE  = 128;      // +1.0 in coefficient format
   localparam int PAM2_LVL  = 64;       // +1.0 in equalizer output format

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRAIN  = 2'd1,
      ST_DD     = 2'd2,
      ST_FREEZE = 2'd3
   } lms_state_e;
endpackage

// File: rtl/ffe_lms_adapt_if.sv
// Sample/control/coefficient bundle between the FFE environment and the LMS engine.
interface ffe_lms_adapt_if #(
   parameter int IN_BW   = ffe_pkg::FFE_IN_BW,
   parameter int EQ_BW   = ffe_pkg::FFE_EQ_BW,
   parameter int COEF_BW = ffe_pkg::FFE_COEF_BW,
   parameter int N_COEF  = ffe_pkg::FFE_N_COEF
);
   logic                        i_en;
   logic [IN_BW-1:0]            i_data;
   logic [EQ_BW-1:0]            i_eq;
   logic                        i_ref;
   logic                        i_start;
   logic                        i_freeze;
   logic [3:0]                  i_mu_shift;
   logic [15:0]                 i_train_len;
   logic [COEF_BW*N_COEF-1:0]   o_coefs;
   logic [EQ_BW:0]              o_error;
   logic [1:0]                  o_state;
   logic                        o_train_done;

   modport master (
      output i_en, i_data, i_eq, i_ref, i_start, i_freeze, i_mu_shift, i_train_len,
      input  o_coefs, o_error, o_state, o_train_done
   );
   modport slave (
      input  i_en, i_data, i_eq, i_ref, i_start, i_freeze, i_mu_shift, i_train_len,
      output o_coefs, o_error, o_state, o_train_done
   );
endinterface

// File: rtl/lms_tap.sv
// One LMS tap: registered e*x product, scaled step, saturating accumulator.
module lms_tap
   import ffe_pkg::*;
#(
   parameter int IN_BW   = FFE_IN_BW,
   parameter int E_BW    = FFE_EQ_BW + 1,
   parameter int COEF_BW = FFE_COEF_BW,
   parameter int EXT_BW  = FFE_EXT_BW,
   parameter int INIT    = 0
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_cap,
   input  logic                      i_init,
   input  logic                      i_upd,
   input  logic signed [E_BW-1:0]    i_e,
   input  logic signed [IN_BW-1:0]   i_x,
   input  logic [MU_BW-1:0]          i_mu_shift,
   output logic [COEF_BW-1:0]        o_coef
);
   localparam int P_BW   = E_BW + IN_BW;
   localparam int ACC_BW = COEF_BW + EXT_BW;
   localparam int SUM_BW = ((P_BW + 4 > ACC_BW) ? P_BW + 4 : ACC_BW) + 1;
   localparam logic signed [SUM_BW-1:0] ACC_MAX = (SUM_BW'(1) <<< (ACC_BW - 1)) - SUM_BW'(1);
   localparam logic signed [SUM_BW-1:0] ACC_MIN = -(SUM_BW'(1) <<< (ACC_BW - 1));

   logic signed [P_BW-1:0]   p_q, p_d;
   logic signed [ACC_BW-1:0] acc_q, acc_d;
   logic signed [P_BW+3:0]   step;
   logic signed [SUM_BW-1:0] sum;

   // Product capture and accumulator update with clamp; reinit wins over update.
   always_comb begin
      p_d   = i_cap ? (P_BW'(i_e) * P_BW'(i_x)) : p_q;
      // <<<4 aligns the product fraction (13) to the accumulator fraction (17)
      step  = $signed({p_q, 4'b0000}) >>> i_mu_shift;
      sum   = SUM_BW'(acc_q) + SUM_BW'(step);
      acc_d = acc_q;
      if (i_init)            acc_d = ACC_BW'(INIT);
      else if (i_upd) begin
         if (sum > ACC_MAX)      acc_d = ACC_BW'(ACC_MAX);
         else if (sum < ACC_MIN) acc_d = ACC_BW'(ACC_MIN);
         else                    acc_d = ACC_BW'(sum);
      end
   end

   // Tap state registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         p_q   <= '0;
         acc_q <= ACC_BW'(INIT);
      end else begin
         p_q   <= p_d;
         acc_q <= acc_d;
      end
   end

   assign o_coef = acc_q[ACC_BW-1 -: COEF_BW];
endmodule

// File: rtl/ffe_lms_adapt.sv
// LMS adaptation engine: x delay line, error/decision, mode FSM and per-tap accumulators.
module ffe_lms_adapt
   import ffe_pkg::*;
#(
   parameter int IN_BW     = FFE_IN_BW,
   parameter int EQ_BW     = FFE_EQ_BW,
   parameter int COEF_BW   = FFE_COEF_BW,
   parameter int N_COEF    = FFE_N_COEF,
   parameter int EXT_BW    = FFE_EXT_BW,
   parameter int ALIGN_DLY = FFE_ALIGN_DLY,
   parameter int CENTER    = FFE_CENTER
) (
   input  logic           i_clk,
   input  logic           i_rst,
   ffe_lms_adapt_if.slave bus
);
   localparam int E_BW = EQ_BW + 1;
   // registers hold x[n-1]..x[n-(N_COEF+ALIGN_DLY-1)]; with the live sample that is the full line
   localparam int DL   = N_COEF + ALIGN_DLY - 1;
   localparam int INIT_CTR = COEF_ONE << EXT_BW;
   localparam logic signed [E_BW-1:0] LVL_P = E_BW'(PAM2_LVL);
   localparam logic signed [E_BW-1:0] LVL_N = E_BW'(-PAM2_LVL);

   lms_state_e                    state_q, state_d;
   logic [TLEN_BW-1:0]            cnt_q, cnt_d;
   logic                          done_q, done_d;
   logic                          vld_q, vld_d;
   logic [DL-1:0][IN_BW-1:0]      xd_q, xd_d;
   logic signed [E_BW-1:0]        err_q, err_d;
   logic signed [E_BW-1:0]        eq_ext, d_lvl, e_now;
   logic                          adapt, upd, reinit;
   logic [N_COEF-1:0][COEF_BW-1:0] coefs;

   // Decision (training symbol or PAM2 slicer) and full-precision error.
   always_comb begin
      eq_ext = E_BW'($signed(bus.i_eq));
      if (state_q == ST_TRAIN) d_lvl = bus.i_ref ? LVL_P : LVL_N;
      else                     d_lvl = bus.i_eq[EQ_BW-1] ? LVL_N : LVL_P;
      e_now  = d_lvl - eq_ext;
   end

   assign adapt = (state_q == ST_TRAIN) || (state_q == ST_DD);
   // freeze/start in the same cycle suppress the in-flight update
   assign upd   = bus.i_en && vld_q && adapt && !bus.i_freeze && !bus.i_start;

   // Next-state: delay line, error register, mode FSM, training counter, stage1 valid.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      vld_d   = vld_q;
      xd_d    = xd_q;
      err_d   = err_q;
      reinit  = 1'b0;
      if (bus.i_en) begin
         xd_d  = {xd_q[DL-2:0], bus.i_data};
         err_d = e_now;
         vld_d = adapt;
      end
      case (state_q)
         ST_TRAIN: begin
            if (bus.i_freeze) state_d = ST_FREEZE;
            else if (bus.i_en) begin
               if (bus.i_train_len == '0 || cnt_q == bus.i_train_len - TLEN_BW'(1)) begin
                  state_d = ST_DD;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + TLEN_BW'(1);
               end
            end
         end
         ST_DD:     if (bus.i_freeze)  state_d = ST_FREEZE;
         ST_FREEZE: if (!bus.i_freeze) state_d = ST_DD;
         default:   ;
      endcase
      if (bus.i_start) begin
         state_d = ST_TRAIN;
         cnt_d   = '0;
         done_d  = 1'b0;
         reinit  = 1'b1;
      end
      // drop the in-flight sample whenever adaptation stops or restarts
      if (bus.i_start || state_d == ST_IDLE || state_d == ST_FREEZE) vld_d = 1'b0;
   end

   // Control and datapath registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         vld_q   <= 1'b0;
         xd_q    <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         vld_q   <= vld_d;
         xd_q    <= xd_d;
         err_q   <= err_d;
      end
   end

   for (genvar k = 0; k < N_COEF; k++) begin : g_tap
      lms_tap #(
         .IN_BW(IN_BW), .E_BW(E_BW), .COEF_BW(COEF_BW), .EXT_BW(EXT_BW),
         .INIT((k == CENTER) ? INIT_CTR : 0)
      ) u_tap (
         .i_clk      (i_clk),
         .i_rst      (i_rst),
         .i_cap      (bus.i_en),
         .i_init     (reinit),
         .i_upd      (upd),
         .i_e        (e_now),
         .i_x        (xd_q[k+ALIGN_DLY-1]),
         .i_mu_shift (bus.i_mu_shift),
         .o_coef     (coefs[k])
      );
   end

   assign bus.o_coefs      = coefs;
   assign bus.o_error      = err_q;
   assign bus.o_state      = state_q;
   assign bus.o_train_done = done_q;
endmodule

// File: tb/tb_ffe_lms_adapt.sv
// Bench for ffe_lms_adapt: directed vector table, random run against a sample-level model,
// identity-channel training run, freeze hold and start/freeze collision sequences.
module tb_ffe_lms_adapt;
   localparam int NC      = 7;
   localparam int CW      = 9 * NC;
   localparam longint AMAX = (64'sd1 << 18) - 1;
   localparam longint AMIN = -(64'sd1 << 18);

   logic clk, rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   ffe_lms_adapt_if bus ();
   ffe_lms_adapt dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   int vecs = 0, bad = 0;

   // behavioural model: sample history, pending products, accumulators as plain integers
   int     m_state, m_cnt, m_err;
   bit     m_done, m_vld;
   longint m_acc[NC], m_p[NC];
   int     m_hist[8];          // m_hist[j] = x[n-1-j]
   bit     d_rst, d_en, d_st, d_fr, d_rf;
   int     d_mu, d_tl, d_dat, d_eq;

   typedef struct {
      bit rst, en, st, fr, rf;
      int dat, eq;
      int est; bit edone; int eerr;
      int c[NC];
   } vec_t;
   vec_t tbl[21];

   function automatic vec_t row(bit r, bit en, bit st, bit fr, bit rf, int dat, int eq,
                                int est, bit edn, int eer,
                                int c0, int c1, int c2, int c3, int c4, int c5, int c6);
      vec_t v;
      v.rst = r; v.en = en; v.st = st; v.fr = fr; v.rf = rf; v.dat = dat; v.eq = eq;
      v.est = est; v.edone = edn; v.eerr = eer;
      v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3; v.c[4] = c4; v.c[5] = c5; v.c[6] = c6;
      return v;
   endfunction

   function automatic longint init_acc(int k);
      return (k == 3) ? (64'sd128 << 10) : 64'sd0;
   endfunction

   function automatic longint sat(longint a);
      if (a > AMAX) return AMAX;
      if (a < AMIN) return AMIN;
      return a;
   endfunction

   task automatic m_reset();
      m_state = 0; m_cnt = 0; m_err = 0; m_done = 0; m_vld = 0;
      for (int k = 0; k < NC; k++) begin m_acc[k] = init_acc(k); m_p[k] = 0; end
      for (int j = 0; j < 8; j++) m_hist[j] = 0;
   endtask

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_step();
      int d, e, nst; bit act, upd;
      if (d_rst) begin m_reset(); return; end
      act = (m_state == 1) || (m_state == 2);
      if (m_state == 1) d = d_rf ? 64 : -64;
      else              d = (d_eq >= 0) ? 64 : -64;
      e   = d - d_eq;
      upd = d_en && m_vld && act && !d_fr && !d_st;
      for (int k = 0; k < NC; k++) begin
         if (d_st)     m_acc[k] = init_acc(k);
         else if (upd) m_acc[k] = sat(m_acc[k] + ((m_p[k] * 16) >>> d_mu));
      end
      nst = m_state;
      case (m_state)
         1: if (d_fr) nst = 3;
            else if (d_en) begin
               if (d_tl == 0 || m_cnt == d_tl - 1) begin nst = 2; m_done = 1; end
               else m_cnt = (m_cnt + 1) % 65536;
            end
         2: if (d_fr) nst = 3;
         3: if (!d_fr) nst = 2;
         default: ;
      endcase
      if (d_st) begin nst = 1; m_cnt = 0; m_done = 0; end
      if (d_en) begin
         for (int k = 0; k < NC; k++) m_p[k] = e * m_hist[k+1];
         m_err = e;
         m_vld = act;
         for (int j = 7; j > 0; j--) m_hist[j] = m_hist[j-1];
         m_hist[0] = d_dat;
      end
      if (d_st || nst == 0 || nst == 3) m_vld = 0;
      m_state = nst;
   endtask

   task automatic apply(bit r, bit en, bit st, bit fr, bit rf, int mu, int tl, int dat, int eq);
      @(negedge clk);
      rst = r; bus.i_en = en; bus.i_start = st; bus.i_freeze = fr; bus.i_ref = rf;
      bus.i_mu_shift = 4'(mu); bus.i_train_len = 16'(tl);
      bus.i_data = 11'(dat); bus.i_eq = 9'(eq);
      d_rst = r; d_en = en; d_st = st; d_fr = fr; d_rf = rf; d_mu = mu; d_tl = tl;
      d_dat = int'($signed(bus.i_data)); d_eq = int'($signed(bus.i_eq));
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic compare(string tag, int idx, int est, bit edone, int eerr, logic [CW-1:0] ec);
      vecs++;
      if (bus.o_coefs !== ec || bus.o_state !== 2'(est) || bus.o_train_done !== edone ||
          bus.o_error !== 10'(eerr)) begin
         bad++;
         $display("FAIL %s #%0d: got st=%0d done=%0d err=%0d coefs=%h, want st=%0d done=%0d err=%0d coefs=%h",
                  tag, idx, bus.o_state, bus.o_train_done, $signed(bus.o_error), bus.o_coefs,
                  est, edone, eerr, ec);
      end
   endtask

   task automatic check_model(string tag, int idx);
      logic [CW-1:0] ec;
      for (int k = 0; k < NC; k++) ec[k*9 +: 9] = 9'(m_acc[k] >>> 10);
      compare(tag, idx, m_state, m_done, m_err, ec);
   endtask

   task automatic expect_int(string tag, int got, int want);
      vecs++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   initial begin
      logic [CW-1:0] ec, snap;
      bit frz, r, st, en;
      int tl, mu, dat;

      rst = 1'b1; bus.i_en = 0; bus.i_start = 0; bus.i_freeze = 0; bus.i_ref = 0;
      bus.i_mu_shift = 0; bus.i_train_len = 0; bus.i_data = 0; bus.i_eq = 0;

      // x=+128 walks through the taps with e=+64, mu=0: each tap gains +1.0 two samples later;
      // C3 starts at +1.0 and clamps at 255.  train_len=3 ends training at the 3rd sample.
      tbl[0]  = row(1,0,0,0,0,   0,  0, 0,0,  0,   0,  0,  0,128,  0,  0,  0);
      tbl[1]  = row(0,0,1,0,0,   0,  0, 1,0,  0,   0,  0,  0,128,  0,  0,  0);
      tbl[2]  = row(0,1,0,0,1, 128,  0, 1,0, 64,   0,  0,  0,128,  0,  0,  0);
      tbl[3]  = row(0,1,0,0,1,   0,  0, 1,0, 64,   0,  0,  0,128,  0,  0,  0);
      tbl[4]  = row(0,1,0,0,1,   0,  0, 2,1, 64,   0,  0,  0,128,  0,  0,  0);
      tbl[5]  = row(0,1,0,0,1,   0,  0, 2,1, 64, 128,  0,  0,128,  0,  0,  0);
      tbl[6]  = row(0,1,0,0,1,   0,  0, 2,1, 64, 128,128,  0,128,  0,  0,  0);
      tbl[7]  = row(0,1,0,0,1,   0,  0, 2,1, 64, 128,128,128,128,  0,  0,  0);
      tbl[8]  = row(0,1,0,0,1,   0,  0, 2,1, 64, 128,128,128,255,  0,  0,  0);
      tbl[9]  = row(0,1,0,0,1,   0,  0, 2,1, 64, 128,128,128,255,128,  0,  0);
      tbl[10] = row(0,1,0,0,1,   0,  0, 2,1, 64, 128,128,128,255,128,128,  0);
      tbl[11] = row(0,1,0,0,1,   0,  0, 2,1, 64, 128,128,128,255,128,128,128);
      tbl[12] = row(0,1,0,1,1,   0,100, 3,1,-36, 128,128,128,255,128,128,128);
      tbl[13] = row(0,1,0,1,1,   0,-10, 3,1,-54, 128,128,128,255,128,128,128);
      tbl[14] = row(0,0,0,0,1,   0,  0, 2,1,-54, 128,128,128,255,128,128,128);
      tbl[15] = row(0,1,1,1,1,   0,  0, 1,0, 64,   0,  0,  0,128,  0,  0,  0);
      tbl[16] = row(0,1,0,0,1,   0,  0, 1,0, 64,   0,  0,  0,128,  0,  0,  0);
      tbl[17] = row(0,1,0,0,1,   0,  0, 1,0, 64,   0,  0,  0,128,  0,  0,  0);
      tbl[18] = row(0,1,0,0,1,   0,  0, 2,1, 64,   0,  0,  0,128,  0,  0,  0);
      tbl[19] = row(0,0,0,0,1,   0,  5, 2,1, 64,   0,  0,  0,128,  0,  0,  0);
      tbl[20] = row(1,1,1,0,1,   0,  0, 0,0,  0,   0,  0,  0,128,  0,  0,  0);

      for (int i = 0; i < 21; i++) begin
         apply(tbl[i].rst, tbl[i].en, tbl[i].st, tbl[i].fr, tbl[i].rf, 0, 3, tbl[i].dat, tbl[i].eq);
         tick();
         for (int k = 0; k < NC; k++) ec[k*9 +: 9] = 9'(tbl[i].c[k]);
         compare("table", i, tbl[i].est, tbl[i].edone, tbl[i].eerr, ec);
      end

      // random traffic against the model
      frz = 0; tl = 10;
      for (int c = 0; c < 3000; c++) begin
         r  = (c == 0) || ($urandom_range(0, 1499) == 0);
         st = (c == 1) || ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 59) == 0) frz = ~frz;
         if ($urandom_range(0, 99) == 0) tl = $urandom_range(0, 30);
         en = ($urandom_range(0, 3) != 0);
         mu = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 15);
         apply(r, en, st, frz, 1'($urandom_range(0, 1)), mu, tl,
               $urandom_range(0, 2047) - 1024, $urandom_range(0, 511) - 256);
         model_step(); tick(); check_model("rand", c);
      end

      // identity channel: i_eq = x[n-2]>>1, training for 1000 samples
      apply(0, 0, 1, 0, 0, 6, 1000, 0, 0);
      model_step(); tick(); check_model("ident_start", 0);
      for (int i = 0; i < 1000; i++) begin
         dat = $urandom_range(0, 1023) - 512;
         apply(0, 1, 0, 0, 1'($urandom_range(0, 1)), 6, 1000, dat, m_hist[1] >>> 1);
         model_step(); tick(); check_model("ident", i);
         if (i == 998) expect_int("ident_still_train", int'(bus.o_state), 1);
         if (i == 999) begin
            expect_int("ident_to_dd", int'(bus.o_state), 2);
            expect_int("ident_train_done", int'(bus.o_train_done), 1);
         end
      end

      // freeze in DD for 50 samples: coefficients hold at their pre-freeze value
      for (int k = 0; k < NC; k++) snap[k*9 +: 9] = 9'(m_acc[k] >>> 10);
      for (int i = 0; i < 50; i++) begin
         apply(0, 1, 0, 1, 0, 2, 1000, $urandom_range(0, 2047) - 1024, $urandom_range(0, 511) - 256);
         model_step(); tick(); check_model("freeze", i);
         vecs++;
         if (bus.o_coefs !== snap) begin
            bad++;
            $display("FAIL freeze_hold #%0d: got coefs=%h, want %h", i, bus.o_coefs, snap);
         end
      end
      apply(0, 0, 0, 0, 0, 2, 1000, 0, 0);
      model_step(); tick(); check_model("freeze_release", 0);
      expect_int("release_to_dd", int'(bus.o_state), 2);

      // start and freeze together in DD: start wins, coefficients reload
      apply(0, 1, 1, 1, 0, 2, 1000, 100, 30);
      model_step(); tick();
      ec = '0; ec[3*9 +: 9] = 9'd128;
      compare("start_beats_freeze", 0, 1, 1'b0, 34, ec);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
      $finish;
   end
endmodule
